// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny line-buffer fetch sequencer.
package canny_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } seqStateT;

    localparam int unsigned TAPS = 4;

    // Whole image rows in the frame; a partial trailing row is ignored.
    function automatic int unsigned nRows(
        input int unsigned startAddress,
        input int unsigned endAddress,
        input int unsigned rowWords
    );
        return (endAddress - startAddress + 1) / rowWords;
    endfunction

endpackage

// File: rtl/canny_addr_gen.sv
// Row/column/tap counters and incremental read-address generation for the
// 4-row window walk (column fastest, then window row).
module canny_addr_gen
    import canny_pkg::*;
#(
    parameter int unsigned STARTADDRESS = 0,
    parameter int unsigned ENDADDRESS   = 2097151,
    parameter int unsigned ROWWORDS     = 256,
    parameter int unsigned ADDRW        = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tapInc,
    input  logic             colInc,
    output logic [ADDRW-1:0] addr,
    output logic [1:0]       tap,
    output logic             lastTap,
    output logic             lastWindow
);

    localparam int unsigned NROWS   = nRows(STARTADDRESS, ENDADDRESS, ROWWORDS);
    localparam int unsigned LASTROW = (NROWS >= TAPS) ? (NROWS - TAPS) : 0;
    localparam int unsigned COLW    = (ROWWORDS > 1) ? $clog2(ROWWORDS) : 1;

    logic [ADDRW-1:0] rowBase;
    logic [ADDRW-1:0] tapOffset;
    logic [ADDRW-1:0] row;
    logic [COLW-1:0]  col;
    logic             colLast;

    assign colLast    = (col == COLW'(ROWWORDS - 1));
    assign lastTap    = (tap == 2'd3);
    assign lastWindow = (row == ADDRW'(LASTROW)) && colLast;
    assign addr       = rowBase + tapOffset + ADDRW'(col);

    // tapOffset tracks k*ROWWORDS so no multiplier is needed
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rowBase   <= ADDRW'(STARTADDRESS);
            tapOffset <= '0;
            row       <= '0;
            col       <= '0;
            tap       <= 2'd0;
        end else begin
            if (tapInc) begin
                tap       <= tap + 2'd1;
                tapOffset <= lastTap ? '0 : tapOffset + ADDRW'(ROWWORDS);
            end
            if (colInc) begin
                if (colLast) begin
                    col     <= '0;
                    row     <= row + ADDRW'(1);
                    rowBase <= rowBase + ADDRW'(ROWWORDS);
                end else begin
                    col <= col + COLW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/canny_fetch_sequencer.sv
// Request/acknowledge read sequencer feeding the Canny line buffer: four
// tap reads per column, then a window handshake with the downstream filter.
module canny_fetch_sequencer
    import canny_pkg::*;
#(
    parameter int unsigned STARTADDRESS = 0,
    parameter int unsigned ENDADDRESS   = 2097151,
    parameter int unsigned ROWWORDS     = 256,
    parameter int unsigned ADDRW        = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             readReq,
    output logic [ADDRW-1:0] readAddr,
    input  logic             readAck,
    output logic             captureEn,
    output logic [1:0]       tapIndex,
    output logic             windowValid,
    input  logic             windowReady,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NROWS      = nRows(STARTADDRESS, ENDADDRESS, ROWWORDS);
    localparam bit          SHORTFRAME = (NROWS < TAPS);

    seqStateT         state;
    seqStateT         nextState;
    logic [ADDRW-1:0] genAddr;
    logic [1:0]       genTap;
    logic             lastTap;
    logic             lastWindow;
    logic             genClear;
    logic             tapInc;
    logic             colInc;

    assign captureEn = readReq & readAck;
    assign tapInc    = captureEn;
    assign colInc    = windowValid & windowReady;
    assign genClear  = (state == IDLE);

    canny_addr_gen #(
        .STARTADDRESS(STARTADDRESS),
        .ENDADDRESS  (ENDADDRESS),
        .ROWWORDS    (ROWWORDS),
        .ADDRW       (ADDRW)
    ) uAddrGen (
        .clk       (clk),
        .reset     (reset),
        .clear     (genClear),
        .tapInc    (tapInc),
        .colInc    (colInc),
        .addr      (genAddr),
        .tap       (genTap),
        .lastTap   (lastTap),
        .lastWindow(lastWindow)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = SHORTFRAME ? DONE : REQ;
            REQ:  if (readAck && lastTap) nextState = EMIT;
            EMIT: if (windowReady) nextState = lastWindow ? DONE : REQ;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Address and tap are only driven while a request is outstanding
    always_comb begin
        readReq     = 1'b0;
        readAddr    = '0;
        tapIndex    = 2'd0;
        windowValid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            REQ: begin
                readReq  = 1'b1;
                readAddr = genAddr;
                tapIndex = genTap;
                busy     = 1'b1;
            end
            EMIT: begin
                windowValid = 1'b1;
                busy        = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_canny_fetch_sequencer.sv
// Scoreboard bench for canny_fetch_sequencer on a 4-word x 6-row frame,
// plus a 3-row frame instance that must finish without reading.
module tb_canny_fetch_sequencer;

    localparam int unsigned RW = 4;
    localparam int unsigned AW = 24;

    logic          clk;
    logic          reset;
    logic          start;
    logic          readReq;
    logic [AW-1:0] readAddr;
    logic          readAck;
    logic          captureEn;
    logic [1:0]    tapIndex;
    logic          windowValid;
    logic          windowReady;
    logic          busy;
    logic          done;

    logic          start2;
    logic          readReq2;
    logic [AW-1:0] readAddr2;
    logic          readAck2;
    logic          captureEn2;
    logic [1:0]    tapIndex2;
    logic          windowValid2;
    logic          windowReady2;
    logic          busy2;
    logic          done2;

    canny_fetch_sequencer #(
        .STARTADDRESS(0), .ENDADDRESS(23), .ROWWORDS(RW), .ADDRW(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .readReq(readReq),
        .readAddr(readAddr), .readAck(readAck), .captureEn(captureEn),
        .tapIndex(tapIndex), .windowValid(windowValid),
        .windowReady(windowReady), .busy(busy), .done(done)
    );

    canny_fetch_sequencer #(
        .STARTADDRESS(0), .ENDADDRESS(11), .ROWWORDS(RW), .ADDRW(AW)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .readReq(readReq2),
        .readAddr(readAddr2), .readAck(readAck2), .captureEn(captureEn2),
        .tapIndex(tapIndex2), .windowValid(windowValid2),
        .windowReady(windowReady2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;
    int capCount  = 0;
    int winCount  = 0;
    int doneCount = 0;
    int ackMode   = 0;
    int waitCnt   = 0;

    logic [AW-1:0] expAddrQ[$];
    logic [1:0]    expTapQ[$];

    logic          prevReq = 1'b0;
    logic          prevAck = 1'b0;
    logic [AW-1:0] prevAddr = '0;
    logic [1:0]    prevTap = 2'd0;

    task automatic check(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Full pass: window rows 0..2, columns 0..3, taps 0..3
    task automatic pushPass();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) begin
                    expAddrQ.push_back(AW'((r + k) * 4 + c));
                    expTapQ.push_back(2'(k));
                end
    endtask

    // Memory model: ack always, or after 0-5 wait cycles per request
    initial begin
        readAck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ackMode == 0) begin
                readAck = 1'b1;
            end else if (readReq) begin
                if (waitCnt == 0) begin
                    readAck = 1'b1;
                    waitCnt = $urandom_range(0, 5);
                end else begin
                    readAck = 1'b0;
                    waitCnt--;
                end
            end else begin
                readAck = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pop on every capture, event counting, hold stability
    initial begin
        forever begin
            @(negedge clk);
            if (captureEn) begin
                capCount++;
                if (expAddrQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL capture_unexpected: got capture of addr %0d, required none", readAddr);
                end else begin
                    check("capture_addr", readAddr, expAddrQ.pop_front());
                    check("capture_tap", tapIndex, expTapQ.pop_front());
                end
            end
            if (windowValid && windowReady) winCount++;
            if (done) doneCount++;
            if (readReq && prevReq && !prevAck) begin
                check("hold_addr", readAddr, prevAddr);
                check("hold_tap", tapIndex, prevTap);
            end
            prevReq  = readReq;
            prevAck  = readAck;
            prevAddr = readAddr;
            prevTap  = tapIndex;
        end
    end

    task automatic runPass(input bit holdWin, input bit startMid, output int cycles);
        int holdPhase;
        int holdCnt;
        holdPhase = 0;
        holdCnt   = 0;
        cycles    = 0;
        capCount  = 0;
        winCount  = 0;
        doneCount = 0;
        pushPass();
        start = 1'b1;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #2;
            start  = startMid && (i == 25);
            cycles = i;
            if (i == 1) begin
                check("first_readReq", readReq, 1);
                check("first_readAddr", readAddr, 0);
                check("first_busy", busy, 1);
            end
            if (holdWin && holdPhase == 0 && winCount == 1) begin
                windowReady = 1'b0;
                holdPhase   = 1;
            end
            if (holdPhase == 1 && windowValid) holdPhase = 2;
            if (holdPhase == 2) begin
                check("hold_windowValid", windowValid, 1);
                check("hold_readReq", readReq, 0);
                check("hold_captureEn", captureEn, 0);
                holdCnt++;
                if (holdCnt == 10) begin
                    windowReady = 1'b1;
                    holdPhase   = 3;
                end
            end
            if (done) break;
        end
        check("pass_done", done, 1);
        check("busy_at_done", busy, 0);
        start = 1'b0;
        windowReady = 1'b1;
        @(posedge clk);
        #2;
        check("done_one_cycle", done, 0);
        check("pass_captures", capCount, 48);
        check("pass_windows", winCount, 12);
        check("pass_done_pulses", doneCount, 1);
        check("scoreboard_drained", expAddrQ.size(), 0);
    endtask

    initial begin
        int cyc;
        bit found;
        reset        = 1'b1;
        start        = 1'b0;
        windowReady  = 1'b1;
        start2       = 1'b0;
        readAck2     = 1'b1;
        windowReady2 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_readReq", readReq, 0);
        check("rst_readAddr", readAddr, 0);
        check("rst_tapIndex", tapIndex, 0);
        check("rst_windowValid", windowValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Stray acks while idle
        repeat (5) @(posedge clk);
        #2;
        check("idle_captures", capCount, 0);
        check("idle_readReq", readReq, 0);

        // Back-to-back acks, 5 cycles per column, done at cycle 61
        runPass(1'b0, 1'b0, cyc);
        check("passA_cycles", cyc, 61);

        // Window stall plus a start pulse mid-pass
        runPass(1'b1, 1'b1, cyc);

        // Reset during tap 2 of column 1
        capCount = 0;
        winCount = 0;
        for (int k = 0; k < 4; k++) begin
            expAddrQ.push_back(AW'(k * 4));
            expTapQ.push_back(2'(k));
        end
        for (int k = 0; k < 3; k++) begin
            expAddrQ.push_back(AW'(k * 4 + 1));
            expTapQ.push_back(2'(k));
        end
        found = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            if (readReq && tapIndex == 2'd2 && winCount == 1) begin
                found = 1'b1;
                break;
            end
        end
        check("reset_point_reached", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_readReq", readReq, 0);
        check("midrst_readAddr", readAddr, 0);
        check("midrst_tapIndex", tapIndex, 0);
        check("midrst_captureEn", captureEn, 0);
        check("midrst_windowValid", windowValid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("midrst_captures", capCount, 7);
        check("midrst_scoreboard", expAddrQ.size(), 0);

        // Restart from address 0 with random ack latency
        ackMode = 1;
        runPass(1'b0, 1'b0, cyc);
        ackMode = 0;

        // Three-row frame: done one cycle after start, no reads
        check("short_done_before", done2, 0);
        start2 = 1'b1;
        @(posedge clk);
        #2;
        start2 = 1'b0;
        check("short_done", done2, 1);
        check("short_readReq", readReq2, 0);
        check("short_busy", busy2, 0);
        check("short_captureEn", captureEn2, 0);
        @(posedge clk);
        #2;
        check("short_done_clear", done2, 0);
        check("short_readReq_after", readReq2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
